// File: rtl/lost_uart_tx.sv
// lost_uart_tx: byte FIFO feeding an asynchronous UART transmitter (8N1 / 8N2, LSB first).
// Define LOST_UART_PARITY_EN to insert an even parity bit after the data bits (8E1 / 8E2).
module lost_uart_tx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       serialout
);

  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(DIV - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOST_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef LOST_UART_PARITY_EN
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0] count_r, count_next_s;
  logic            full_r, empty_r, overflow_r;
  logic            push_s, drop_s, pop_s, tick_s, last_stop_s;
  logic [7:0]      head_s;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r;
  logic            serial_r, busy_r;
`ifdef LOST_UART_PARITY_EN
  logic            par_r;
`endif

  assign push_s      = wr_en & ~full_r;
  assign drop_s      = wr_en & full_r;
  assign tick_s      = (cnt_r == DIV_LAST);
  assign last_stop_s = (idx_r == STOP_LAST);
  assign pop_s       = ~empty_r & ((state_r == S_IDLE) |
                                   ((state_r == S_STOP) & tick_s & last_stop_s));
  assign head_s      = mem_r[rd_ptr_r];

  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;
  assign serialout = serial_r;

  // Next FIFO occupancy from this cycle's accepted push and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNTW'(1);
      2'b01:   count_next_s = count_r - CNTW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; no reset needed since only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // FIFO pointers, registered full/empty and the sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_CNT);
      empty_r <= (count_next_s == CNTW'(0));
      if (drop_s)       overflow_r <= 1'b1;
      else if (ovf_clr) overflow_r <= 1'b0;
    end
  end

  // Transmit FSM; serialout and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      serial_r <= 1'b1;
      busy_r   <= 1'b0;
`ifdef LOST_UART_PARITY_EN
      par_r    <= 1'b0;
`endif
    end else begin
      cnt_r <= ((state_r == S_IDLE) || tick_s) ? CW'(0) : cnt_r + CW'(1);
      case (state_r)
        S_IDLE: begin
          if (!empty_r) begin
            shift_r  <= head_s;
            idx_r    <= 3'd0;
            serial_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= S_START;
`ifdef LOST_UART_PARITY_EN
            par_r    <= parity8(head_s);
`endif
          end else begin
            serial_r <= 1'b1;
            busy_r   <= 1'b0;
          end
        end
        S_START: begin
          if (tick_s) begin
            serial_r <= shift_r[0];
            idx_r    <= 3'd0;
            state_r  <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              idx_r <= 3'd0;
`ifdef LOST_UART_PARITY_EN
              serial_r <= par_r;
              state_r  <= S_PARITY;
`else
              serial_r <= 1'b1;
              state_r  <= S_STOP;
`endif
            end else begin
              idx_r    <= idx_r + 3'd1;
              serial_r <= shift_r[1];
            end
          end
        end
`ifdef LOST_UART_PARITY_EN
        S_PARITY: begin
          if (tick_s) begin
            serial_r <= 1'b1;
            idx_r    <= 3'd0;
            state_r  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick_s) begin
            if (!last_stop_s) begin
              idx_r <= idx_r + 3'd1;
            end else if (!empty_r) begin
              // Back-to-back frame: reload straight into START with no idle bit.
              shift_r  <= head_s;
              idx_r    <= 3'd0;
              serial_r <= 1'b0;
              state_r  <= S_START;
`ifdef LOST_UART_PARITY_EN
              par_r    <= parity8(head_s);
`endif
            end else begin
              serial_r <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= S_IDLE;
            end
          end
        end
        default: begin
          serial_r <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
